// File: rtl/arbitro_rr.sv
// Round-robin pop arbiter for four upstream FIFOs feeding a 4:1 mux.
// Latency: pop is combinational; selector/enb register one cycle after each pop.
// Backpressure: pausa high freezes the arbiter and suppresses pop. Optional macro ARB_CONTADORES_EN.
module arbitro_rr #(
    parameter int MAX_RAFAGA = 4,
    parameter int CONT_BITS  = 8
) (
    input  logic                   clk,
    input  logic                   reset_L,
    input  logic [3:0]             fifo_empty,
    input  logic                   pausa,
    output logic [3:0]             pop,
    output logic [1:0]             selector,
    output logic                   enb
`ifdef ARB_CONTADORES_EN
    ,
    output logic [4*CONT_BITS-1:0] conteo_pops
`endif
);

    // An out-of-range configuration degrades to single-pop bursts rather than
    // producing a burst limit that the 4-bit burst counter cannot reach.
    localparam bit         PARAMS_OK   = (MAX_RAFAGA >= 1) && (MAX_RAFAGA <= 15) && (CONT_BITS >= 1);
    localparam logic [3:0] RAFAGA_LAST = PARAMS_OK ? 4'(MAX_RAFAGA - 1) : 4'd0;

    typedef enum logic {
        IDLE,
        SERVIR
    } estado_t;

    estado_t    state, state_n;
    logic [1:0] grant, grant_n;
    logic [1:0] ptr, ptr_n;
    logic [3:0] rafaga, rafaga_n;

    logic       pop_act;
    logic       rotar;
    logic [1:0] search_base;
    logic       found;
    logic [1:0] found_ch;
    logic [1:0] cand;

    // A pop happens only while serving a non-empty channel with no stall and reset released.
    always_comb begin
        pop_act = (state == SERVIR) && !fifo_empty[grant] && !pausa && reset_L;
        pop     = pop_act ? (4'b0001 << grant) : 4'b0000;
    end

    // First non-empty channel scanning base, base+1, base+2, base+3 (mod 4).
    // From IDLE the scan starts at ptr; on rotation it starts just past the
    // current grant, so the current channel is the last candidate (re-grant).
    always_comb begin
        search_base = (state == IDLE) ? ptr : grant + 2'd1;
        found       = 1'b0;
        found_ch    = search_base;
        cand        = search_base;
        for (int i = 3; i >= 0; i--) begin
            cand = search_base + 2'(i);
            if (!fifo_empty[cand]) begin
                found    = 1'b1;
                found_ch = cand;
            end
        end
    end

    // Next-state logic: grant acquisition from IDLE, burst accounting and rotation.
    always_comb begin
        state_n  = state;
        grant_n  = grant;
        ptr_n    = ptr;
        rafaga_n = rafaga;
        rotar    = 1'b0;
        case (state)
            IDLE: begin
                // No pop in the acquisition cycle; the grant is used from the next one.
                if (!pausa && found) begin
                    grant_n  = found_ch;
                    rafaga_n = 4'd0;
                    state_n  = SERVIR;
                end
            end
            SERVIR: begin
                if (!pausa) begin
                    // Rotate at the end of a full burst, or when the granted
                    // channel has run dry (no pop this cycle, no bubble added).
                    rotar = pop_act ? (rafaga == RAFAGA_LAST) : fifo_empty[grant];
                    if (pop_act && !rotar) begin
                        rafaga_n = rafaga + 4'd1;
                    end
                    if (rotar) begin
                        ptr_n    = grant + 2'd1;
                        rafaga_n = 4'd0;
                        if (found) begin
                            grant_n = found_ch;
                        end else begin
                            state_n = IDLE;
                        end
                    end
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Arbiter state register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_L) begin
            state  <= IDLE;
            grant  <= 2'd0;
            ptr    <= 2'd0;
            rafaga <= 4'd0;
        end else begin
            state  <= state_n;
            grant  <= grant_n;
            ptr    <= ptr_n;
            rafaga <= rafaga_n;
        end
    end

    // Mux control trails pop by one cycle to line up with the FIFO read data;
    // selector keeps its last value across idle cycles.
    always_ff @(posedge clk) begin
        if (!reset_L) begin
            selector <= 2'd0;
            enb      <= 1'b0;
        end else begin
            enb <= pop_act;
            if (pop_act) begin
                selector <= grant;
            end
        end
    end

`ifdef ARB_CONTADORES_EN
    // Per-channel pop counters, free-running and wrapping at 2^CONT_BITS.
    always_ff @(posedge clk) begin
        if (!reset_L) begin
            conteo_pops <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (pop[i]) begin
                    conteo_pops[i*CONT_BITS +: CONT_BITS] <=
                        conteo_pops[i*CONT_BITS +: CONT_BITS] + CONT_BITS'(1);
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_arbitro_rr.sv
// Directed bench for arbitro_rr: small FIFO occupancy model drives fifo_empty,
// each scenario compares pop/selector/enb cycle by cycle against hand tables.
module tb_arbitro_rr;

    logic       clk = 1'b0;
    logic       reset_L;
    logic [3:0] fifo_empty;
    logic       pausa;
    logic [3:0] pop;
    logic [1:0] selector;
    logic       enb;
`ifdef ARB_CONTADORES_EN
    logic [7:0] conteo_pops;
`endif

    int cnt [4];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

`ifdef ARB_CONTADORES_EN
    arbitro_rr #(.MAX_RAFAGA(4), .CONT_BITS(2)) dut (
        .clk(clk), .reset_L(reset_L), .fifo_empty(fifo_empty), .pausa(pausa),
        .pop(pop), .selector(selector), .enb(enb), .conteo_pops(conteo_pops)
    );
`else
    arbitro_rr #(.MAX_RAFAGA(4), .CONT_BITS(2)) dut (
        .clk(clk), .reset_L(reset_L), .fifo_empty(fifo_empty), .pausa(pausa),
        .pop(pop), .selector(selector), .enb(enb)
    );
`endif

    function automatic logic [1:0] idx(input logic [3:0] oh);
        case (oh)
            4'b0010: idx = 2'd1;
            4'b0100: idx = 2'd2;
            4'b1000: idx = 2'd3;
            default: idx = 2'd0;
        endcase
    endfunction

    task automatic update_empty();
        for (int i = 0; i < 4; i++) fifo_empty[i] = (cnt[i] == 0);
    endtask

    // One clock cycle: apply pausa, sample outputs at negedge, then retire the
    // popped word from the FIFO model just after the rising edge.
    task automatic tick(input logic p, output logic [3:0] o_pop,
                        output logic [1:0] o_sel, output logic o_enb);
        pausa = p;
        @(negedge clk);
        o_pop = pop;
        o_sel = selector;
        o_enb = enb;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) if (o_pop[i] && cnt[i] > 0) cnt[i]--;
        update_empty();
    endtask

    task automatic do_reset(input int c0, input int c1, input int c2, input int c3);
        logic [3:0] p;
        logic [1:0] s;
        logic       e;
        reset_L = 1'b0;
        cnt[0] = c0; cnt[1] = c1; cnt[2] = c2; cnt[3] = c3;
        update_empty();
        tick(1'b0, p, s, e);
        tick(1'b0, p, s, e);
        reset_L = 1'b1;
    endtask

    task automatic test_reset();
        logic [3:0] p;
        logic [1:0] s;
        logic       e;
        do_reset(0, 2, 8, 0);
        tick(1'b0, p, s, e);  // c0: IDLE right after reset
        checks++; if (p !== 4'b0000) begin errors++; $display("FAIL reset_pop got=%b exp=0000", p); end
        checks++; if (s !== 2'd0) begin errors++; $display("FAIL reset_sel got=%0d exp=0", s); end
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL reset_enb got=%b exp=0", e); end
        tick(1'b0, p, s, e);  // c1
        checks++; if (p !== 4'b0010) begin errors++; $display("FAIL reset_c1_pop got=%b exp=0010", p); end
        tick(1'b0, p, s, e);  // c2
        tick(1'b0, p, s, e);  // c3: ch1 dry, rotate to ch2
        checks++; if (p !== 4'b0000) begin errors++; $display("FAIL reset_c3_pop got=%b exp=0000", p); end
        tick(1'b0, p, s, e);  // c4
        checks++; if (p !== 4'b0100) begin errors++; $display("FAIL reset_c4_pop got=%b exp=0100", p); end
        tick(1'b0, p, s, e);  // c5
        reset_L = 1'b0;
        cnt[0] = 3;
        update_empty();
        tick(1'b0, p, s, e);  // c6: reset low mid-burst
        checks++; if (p !== 4'b0000) begin errors++; $display("FAIL reset_midburst_pop got=%b exp=0000", p); end
        checks++; if (s !== 2'd2 || e !== 1'b1) begin errors++; $display("FAIL reset_pre_edge got sel=%0d enb=%b exp sel=2 enb=1", s, e); end
        tick(1'b0, p, s, e);  // c7: after first reset edge
        checks++; if (p !== 4'b0000) begin errors++; $display("FAIL reset_hold_pop got=%b exp=0000", p); end
        checks++; if (s !== 2'd0 || e !== 1'b0) begin errors++; $display("FAIL reset_post_edge got sel=%0d enb=%b exp sel=0 enb=0", s, e); end
`ifdef ARB_CONTADORES_EN
        checks++; if (conteo_pops !== 8'h00) begin errors++; $display("FAIL reset_counters got=%h exp=00", conteo_pops); end
`endif
        reset_L = 1'b1;
        tick(1'b0, p, s, e);  // c8: IDLE, search from ch0
        checks++; if (p !== 4'b0000) begin errors++; $display("FAIL reset_release_pop got=%b exp=0000", p); end
        tick(1'b0, p, s, e);  // c9
        checks++; if (p !== 4'b0001) begin errors++; $display("FAIL reset_first_grant got=%b exp=0001", p); end
    endtask

    task automatic test_round_robin();
        logic [3:0] p, ep;
        logic [1:0] s, last_sel;
        logic       e;
        logic [3:0] prev;
        do_reset(8, 8, 8, 8);
        last_sel = 2'd0;
        prev     = 4'b0000;
        for (int k = 0; k <= 20; k++) begin
            ep = (k == 0) ? 4'b0000 : (4'b0001 << (((k - 1) / 4) % 4));
            tick(1'b0, p, s, e);
            checks++; if (p !== ep) begin errors++; $display("FAIL rr_pop k=%0d got=%b exp=%b", k, p, ep); end
            if (k >= 1) begin
                if (prev != 4'b0000) last_sel = idx(prev);
                checks++; if (e !== (prev != 4'b0000) || s !== last_sel) begin
                    errors++; $display("FAIL rr_mux k=%0d got sel=%0d enb=%b exp sel=%0d enb=%b", k, s, e, last_sel, prev != 4'b0000);
                end
            end
            prev = ep;
        end
    endtask

    task automatic test_early_empty();
        logic [3:0] exp_p [11] = '{4'h0, 4'h2, 4'h2, 4'h0, 4'h8, 4'h8, 4'h8, 4'h8, 4'h8, 4'h0, 4'h0};
        logic [3:0] p, prev;
        logic [1:0] s, last_sel;
        logic       e;
        do_reset(0, 2, 0, 5);
        last_sel = 2'd0;
        prev     = 4'b0000;
        for (int k = 0; k < 11; k++) begin
            tick(1'b0, p, s, e);
            checks++; if (p !== exp_p[k]) begin errors++; $display("FAIL early_pop k=%0d got=%b exp=%b", k, p, exp_p[k]); end
            if (k >= 1) begin
                if (prev != 4'b0000) last_sel = idx(prev);
                checks++; if (e !== (prev != 4'b0000) || s !== last_sel) begin
                    errors++; $display("FAIL early_mux k=%0d got sel=%0d enb=%b exp sel=%0d enb=%b", k, s, e, last_sel, prev != 4'b0000);
                end
            end
            prev = exp_p[k];
        end
    endtask

    task automatic test_stall();
        logic [3:0] exp_p [10] = '{4'h0, 4'h1, 4'h1, 4'h0, 4'h0, 4'h0, 4'h1, 4'h1, 4'h2, 4'h2};
        logic       stl   [10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        logic [3:0] p, prev;
        logic [1:0] s, last_sel;
        logic       e;
        do_reset(8, 8, 0, 0);
        last_sel = 2'd0;
        prev     = 4'b0000;
        for (int k = 0; k < 10; k++) begin
            tick(stl[k], p, s, e);
            checks++; if (p !== exp_p[k]) begin errors++; $display("FAIL stall_pop k=%0d got=%b exp=%b", k, p, exp_p[k]); end
            if (k >= 1) begin
                if (prev != 4'b0000) last_sel = idx(prev);
                checks++; if (e !== (prev != 4'b0000) || s !== last_sel) begin
                    errors++; $display("FAIL stall_mux k=%0d got sel=%0d enb=%b exp sel=%0d enb=%b", k, s, e, last_sel, prev != 4'b0000);
                end
            end
            prev = exp_p[k];
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] p, ep;
        logic [1:0] s;
        logic       e;
        do_reset(0, 0, 10, 0);
        for (int k = 0; k <= 11; k++) begin
            ep = (k >= 1 && k <= 10) ? 4'b0100 : 4'b0000;
            tick(1'b0, p, s, e);
            checks++; if (p !== ep) begin errors++; $display("FAIL regrant_pop k=%0d got=%b exp=%b", k, p, ep); end
            if (k >= 2 && k <= 11) begin
                checks++; if (e !== 1'b1 || s !== 2'd2) begin errors++; $display("FAIL regrant_mux k=%0d got sel=%0d enb=%b exp sel=2 enb=1", k, s, e); end
            end
        end
    endtask

`ifdef ARB_CONTADORES_EN
    task automatic test_counters();
        logic [3:0] p;
        logic [1:0] s;
        logic       e;
        int         npops;
        do_reset(5, 0, 0, 0);
        npops = 0;
        for (int k = 0; k < 7; k++) begin
            tick(1'b0, p, s, e);
            if (p == 4'b0001) npops++;
        end
        checks++; if (npops != 5) begin errors++; $display("FAIL cnt_pops got=%0d exp=5", npops); end
        checks++; if (conteo_pops !== 8'h01) begin errors++; $display("FAIL cnt_wrap got=%h exp=01", conteo_pops); end
    endtask
`endif

    initial begin
        reset_L    = 1'b0;
        pausa      = 1'b0;
        fifo_empty = 4'hF;
        test_reset();
        test_round_robin();
        test_early_empty();
        test_stall();
        test_back_to_back();
`ifdef ARB_CONTADORES_EN
        test_counters();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
